// File: rtl/e_md_controller.sv
`default_nettype none
// ============================================================================
// Module      : e_md_controller
// Description : Execute-stage multiply/divide controller. Accepts one
//               MULT/MULTU/DIV/DIVU per issue, holds the result in temporary
//               registers for a fixed latency, then commits it to HI/LO.
//               Also handles MTHI/MTLO writes, MFHI/MFLO reads and the
//               stall request consumed by the hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
module e_md_controller #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDOp,
    input  logic [31:0] E_RS,
    input  logic [31:0] E_RT,
    input  logic        E_Cancel,
    input  logic        D_IsMDInst,
    output logic        E_Busy,
    output logic        MD_Stall,
    output logic [31:0] E_MDOut,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        t_hi;
    logic [31:0]        t_lo;
    logic               t_div_zero;
    logic               busy;

    logic               is_idle;
    logic               is_start;
    logic               is_mult_op;
    logic               is_div_op;
    logic               write_ok;

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        rt_safe;
    logic               rs_neg;
    logic               rt_neg;
    logic [31:0]        rs_mag;
    logic [31:0]        rt_mag;
    logic [31:0]        sq_mag;
    logic [31:0]        sr_mag;
    logic [31:0]        calc_hi;
    logic [31:0]        calc_lo;
    logic               calc_div_zero;

    assign is_idle    = (state == ST_IDLE);
    assign is_mult_op = (E_MDOp == OP_MULT) || (E_MDOp == OP_MULTU);
    assign is_div_op  = (E_MDOp == OP_DIV)  || (E_MDOp == OP_DIVU);
    assign write_ok   = is_idle && !E_Cancel;
    assign is_start   = write_ok && (is_mult_op || is_div_op);

    // The start cycle must stall D immediately, before the state register moves
    assign MD_Stall = D_IsMDInst && (busy || is_start);
    assign E_Busy   = busy;

    // Move-from reads the architectural registers only; the stall hides temps
    always_comb begin
        E_MDOut = 32'd0;
        if (E_MDOp == OP_MFHI) begin
            E_MDOut = HI;
        end else if (E_MDOp == OP_MFLO) begin
            E_MDOut = LO;
        end
    end

    // Result computation for the op being started this cycle
    always_comb begin
        // Low 64 bits of the product of sign-extended operands equal the signed product
        prod_s  = {{32{E_RS[31]}}, E_RS} * {{32{E_RT[31]}}, E_RT};
        prod_u  = {32'd0, E_RS} * {32'd0, E_RT};
        // Zero divisor is replaced so the divider never sees it; the result is discarded
        rt_safe = (E_RT == 32'd0) ? 32'd1 : E_RT;
        rs_neg  = E_RS[31];
        rt_neg  = rt_safe[31];
        rs_mag  = rs_neg ? (32'd0 - E_RS) : E_RS;
        rt_mag  = rt_neg ? (32'd0 - rt_safe) : rt_safe;
        // Magnitude division keeps 0x80000000 / -1 well defined (wraps to 0x80000000)
        sq_mag  = rs_mag / rt_mag;
        sr_mag  = rs_mag % rt_mag;

        calc_hi       = 32'd0;
        calc_lo       = 32'd0;
        calc_div_zero = 1'b0;
        case (E_MDOp)
            OP_MULT: begin
                calc_hi = prod_s[63:32];
                calc_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                calc_hi = prod_u[63:32];
                calc_lo = prod_u[31:0];
            end
            OP_DIV: begin
                calc_lo       = (rs_neg ^ rt_neg) ? (32'd0 - sq_mag) : sq_mag;
                calc_hi       = rs_neg ? (32'd0 - sr_mag) : sr_mag;
                calc_div_zero = (E_RT == 32'd0);
            end
            OP_DIVU: begin
                calc_lo       = E_RS / rt_safe;
                calc_hi       = E_RS % rt_safe;
                calc_div_zero = (E_RT == 32'd0);
            end
            default: begin
                calc_hi       = 32'd0;
                calc_lo       = 32'd0;
                calc_div_zero = 1'b0;
            end
        endcase
    end

    // Sequencer: start, countdown, commit to HI/LO, and move-to writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            t_hi       <= 32'd0;
            t_lo       <= 32'd0;
            t_div_zero <= 1'b0;
            busy       <= 1'b0;
            HI         <= 32'd0;
            LO         <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_start) begin
                        t_hi       <= calc_hi;
                        t_lo       <= calc_lo;
                        t_div_zero <= calc_div_zero;
                        busy       <= 1'b1;
                        if (is_mult_op) begin
                            cnt   <= CNT_W'(MULT_CYCLES);
                            state <= ST_MUL;
                        end else begin
                            cnt   <= CNT_W'(DIV_CYCLES);
                            state <= ST_DIV;
                        end
                    end else if (write_ok && (E_MDOp == OP_MTHI)) begin
                        HI <= E_RS;
                    end else if (write_ok && (E_MDOp == OP_MTLO)) begin
                        LO <= E_RS;
                    end
                end
                ST_MUL, ST_DIV: begin
                    // Cancel has no effect here: an in-flight op always completes
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        if (!t_div_zero) begin
                            HI <= t_hi;
                            LO <= t_lo;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_e_md_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_e_md_controller
// Description : Directed self-checking bench for e_md_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_e_md_controller;

    logic        clk;
    logic        reset;
    logic [3:0]  E_MDOp;
    logic [31:0] E_RS;
    logic [31:0] E_RT;
    logic        E_Cancel;
    logic        D_IsMDInst;
    logic        E_Busy;
    logic        MD_Stall;
    logic [31:0] E_MDOut;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fail   = 0;

    // Bench's own view of the architectural registers
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    e_md_controller #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .E_MDOp     (E_MDOp),
        .E_RS       (E_RS),
        .E_RT       (E_RT),
        .E_Cancel   (E_Cancel),
        .D_IsMDInst (D_IsMDInst),
        .E_Busy     (E_Busy),
        .MD_Stall   (MD_Stall),
        .E_MDOut    (E_MDOut),
        .HI         (HI),
        .LO         (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        E_MDOp   = 4'd0;
        E_RS     = 32'd0;
        E_RT     = 32'd0;
        E_Cancel = 1'b0;
    endtask

    // Issue one multi-cycle op and follow it through busy to commit
    task automatic run_md(input string name, input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input int n, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        D_IsMDInst = 1'b1;
        E_Cancel   = 1'b0;
        E_MDOp     = op;
        E_RS       = rs;
        E_RT       = rt;
        #1;
        n_checks++;
        if (MD_Stall !== 1'b1) begin
            n_fail++;
            $display("FAIL %s start_stall: got %b expected 1", name, MD_Stall);
        end
        step();
        idle_inputs();
        for (int i = 1; i <= n; i++) begin
            #1;
            n_checks++;
            if (E_Busy !== 1'b1 || MD_Stall !== 1'b1 || HI !== m_hi || LO !== m_lo) begin
                n_fail++;
                $display("FAIL %s busy_cycle%0d: busy=%b stall=%b hi=%h lo=%h expected busy=1 stall=1 hi=%h lo=%h",
                         name, i, E_Busy, MD_Stall, HI, LO, m_hi, m_lo);
            end
            step();
        end
        n_checks++;
        if (E_Busy !== 1'b0 || MD_Stall !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
            n_fail++;
            $display("FAIL %s commit: busy=%b stall=%b hi=%h lo=%h expected busy=0 stall=0 hi=%h lo=%h",
                     name, E_Busy, MD_Stall, HI, LO, exp_hi, exp_lo);
        end
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        D_IsMDInst = 1'b0;
        idle_inputs();
        m_hi = 32'd0;
        m_lo = 32'd0;
        #2;
        n_checks++;
        if (E_Busy !== 1'b0 || MD_Stall !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || E_MDOut !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b stall=%b hi=%h lo=%h out=%h expected all zero",
                     E_Busy, MD_Stall, HI, LO, E_MDOut);
        end
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_mult();
        run_md("mult", 4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        // MFLO right after busy falls, D still holding an MD op: no stall
        D_IsMDInst = 1'b1;
        E_MDOp     = 4'd8;
        #1;
        n_checks++;
        if (E_MDOut !== 32'hFFFFFFFA || MD_Stall !== 1'b0) begin
            n_fail++;
            $display("FAIL mflo_after_mult: out=%h stall=%b expected out=fffffffa stall=0", E_MDOut, MD_Stall);
        end
        step();
        idle_inputs();
        run_md("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
    endtask

    task automatic test_div();
        run_md("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("divu_zero", 4'd4, 32'd7, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
        run_md("divu_big", 4'd4, 32'hFFFFFFFF, 32'd16, 10, 32'h0000000F, 32'h0FFFFFFF);
    endtask

    task automatic test_back_to_back();
        // Second op starts in the first cycle with busy low
        run_md("b2b_a", 4'd1, 32'd6, 32'd7, 5, 32'd0, 32'd42);
        run_md("b2b_b", 4'd3, 32'd100, 32'hFFFFFFF9, 10, 32'd2, 32'hFFFFFFF2);
    endtask

    task automatic test_cancel();
        // Cancelled start: no stall, no busy, registers untouched
        D_IsMDInst = 1'b1;
        E_MDOp     = 4'd1;
        E_RS       = 32'd9;
        E_RT       = 32'd9;
        E_Cancel   = 1'b1;
        #1;
        n_checks++;
        if (MD_Stall !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_start_stall: got %b expected 0", MD_Stall);
        end
        step();
        idle_inputs();
        step();
        n_checks++;
        if (E_Busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
            n_fail++;
            $display("FAIL cancel_start: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h",
                     E_Busy, HI, LO, m_hi, m_lo);
        end
        // Cancel during busy cycle 2 must not abort the multiply
        E_MDOp = 4'd1;
        E_RS   = 32'h00010000;
        E_RT   = 32'h00010000;
        step();
        idle_inputs();
        for (int i = 1; i <= 5; i++) begin
            E_Cancel = (i == 2);
            step();
        end
        E_Cancel = 1'b0;
        n_checks++;
        if (E_Busy !== 1'b0 || HI !== 32'd1 || LO !== 32'd0) begin
            n_fail++;
            $display("FAIL cancel_in_flight: busy=%b hi=%h lo=%h expected busy=0 hi=00000001 lo=00000000",
                     E_Busy, HI, LO);
        end
        m_hi = 32'd1;
        m_lo = 32'd0;
    endtask

    task automatic test_move();
        D_IsMDInst = 1'b1;
        E_MDOp     = 4'd5;
        E_RS       = 32'h12345678;
        step();
        E_MDOp = 4'd7;
        E_RS   = 32'd0;
        #1;
        n_checks++;
        if (E_MDOut !== 32'h12345678 || MD_Stall !== 1'b0 || E_Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi_mfhi: out=%h stall=%b busy=%b expected out=12345678 stall=0 busy=0",
                     E_MDOut, MD_Stall, E_Busy);
        end
        m_hi = 32'h12345678;
        E_MDOp   = 4'd6;
        E_RS     = 32'hDEADBEEF;
        E_Cancel = 1'b1;
        step();
        E_Cancel = 1'b0;
        E_MDOp   = 4'd8;
        #1;
        n_checks++;
        if (LO !== m_lo || E_MDOut !== m_lo) begin
            n_fail++;
            $display("FAIL mtlo_cancel: lo=%h out=%h expected %h", LO, E_MDOut, m_lo);
        end
        E_MDOp = 4'd6;
        E_RS   = 32'hCAFEF00D;
        step();
        m_lo   = 32'hCAFEF00D;
        E_MDOp = 4'd9;
        #1;
        n_checks++;
        if (LO !== 32'hCAFEF00D || E_MDOut !== 32'd0 || MD_Stall !== 1'b0) begin
            n_fail++;
            $display("FAIL mtlo_op9: lo=%h out=%h stall=%b expected lo=cafef00d out=0 stall=0",
                     LO, E_MDOut, MD_Stall);
        end
        step();
        idle_inputs();
        n_checks++;
        if (E_Busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
            n_fail++;
            $display("FAIL op9_none: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h",
                     E_Busy, HI, LO, m_hi, m_lo);
        end
    endtask

    task automatic test_reset_mid_div();
        D_IsMDInst = 1'b0;
        E_MDOp     = 4'd4;
        E_RS       = 32'd50;
        E_RT       = 32'd7;
        step();
        idle_inputs();
        for (int i = 1; i <= 3; i++) step();
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (E_Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_div: busy=%b hi=%h lo=%h expected busy=0 hi=0 lo=0", E_Busy, HI, LO);
        end
        step();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) step();
        n_checks++;
        if (E_Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_fail++;
            $display("FAIL no_commit_after_reset: busy=%b hi=%h lo=%h expected busy=0 hi=0 lo=0",
                     E_Busy, HI, LO);
        end
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_back_to_back();
        test_cancel();
        test_move();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
